hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Producer-side companion to the EX-stage forwarding unit in the 5-stage RV32I pipeline.
- The forwarding unit resolves hazards that bypass can cover. This block detects the hazards bypass cannot cover and stalls or flushes the front end:
  - load-use hazards;
  - writes from the multi-cycle mul/div unit that are still outstanding;
  - taken-branch redirects.
- Sits beside the ID stage. It drives the PC, IF/ID and ID/EX register controls.

Parameters:
- NREG, 32, number of architectural registers; index width is log2(NREG)=5.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- rs1_id  in  5  ID-stage source 1
- rs2_id  in  5  ID-stage source 2
- use_rs1_id  in  1  instruction in ID reads rs1
- use_rs2_id  in  1  instruction in ID reads rs2
- rd_id  in  5  ID-stage destination
- RUWr_id  in  1  instruction in ID writes the register unit
- load_id  in  1  instruction in ID is a load
- long_id  in  1  instruction in ID issues to the mul/div unit
- long_done  in  1  mul/div result is on the writeback bus this cycle
- long_rd  in  5  destination of the completing mul/div result
- branch_taken_ex  in  1  EX-stage redirect
- stall_pc  out  1  hold the PC
- stall_ifid  out  1  hold IF/ID
- bubble_idex  out  1  load a NOP into ID/EX
- flush_ifid  out  1  clear IF/ID to a NOP
- pending  out  32  scoreboard vector; bit i means a long write to xi is outstanding
- hazard_state  out  2  registered cause of the last cycle: 0 RUN, 1 LOAD_STALL, 2 LONG_STALL, 3 FLUSH
- stall_cycles  out  CNT_W  saturating count of cycles with stall_ifid=1

Behaviour:
Reset (synchronous, rst=1 at a rising edge):
- pending=0, hazard_state=RUN, stall_cycles=0.
- Internal ex_load_q=0, ex_rd_q=0.
- Combinational outputs are evaluated from these reset values.

Hazard terms (combinational, same cycle as inputs):
- src_match(r) = r!=0 and ((use_rs1_id and rs1_id==r) or (use_rs2_id and rs2_id==r)).
- done_mask = a one-hot of long_rd when long_done=1 and long_rd!=0, else 0. This models a same-cycle release, because the result is forwarded from WB.
- eff_pend = pending & ~done_mask.
- load_haz = ex_load_q and src_match(ex_rd_q).
- long_haz is true when any of these holds:
  - a used rs1/rs2 (nonzero) has its eff_pend bit set;
  - (RUWr_id and rd_id!=0 and eff_pend[rd_id]), i.e. a WAW hazard.

Priority:
1. branch_taken_ex=1:
   - flush_ifid=1, bubble_idex=1, stall_pc=0, stall_ifid=0.
   - The ID instruction is wrong-path: it sets no pending bit and is not captured into the EX tracker.
   - next hazard_state=FLUSH.
2. Otherwise long_haz:
   - stall_pc=1, stall_ifid=1, bubble_idex=1.
   - next state=LONG_STALL.
3. Otherwise load_haz:
   - same outputs as long_haz; next state=LOAD_STALL.
4. Otherwise (advance):
   - all four control outputs are 0; next state=RUN.

EX tracker (updates at the clock edge):
- On advance: ex_load_q<=load_id&RUWr_id, ex_rd_q<=rd_id.
- On stall or flush: ex_load_q<=0, matching the bubble.
- A load-use stall therefore lasts exactly 1 cycle.

Scoreboard (updates at the clock edge):
- Clear: pending[long_rd]<=0 when long_done=1.
- Set: on advance with long_id and RUWr_id and rd_id!=0, pending[rd_id]<=1.
- Set wins over clear on the same index in the same cycle.
- Bit 0 is always 0.

Counter:
- stall_cycles increments each cycle stall_ifid=1.
- Holds at 2^CNT_W-1; no wrap.

Other rules:
- rst mid-stall: the reset is taken at that edge; pending is cleared. The core is also being reset, so mul/div results still in flight are discarded.
- long_done for a register whose pending bit is clear: no effect.

Decomposition:
- Shared package holds:
  - the hazard_state encodings (HZ_RUN=0, HZ_LOAD=1, HZ_LONG=2, HZ_FLUSH=3);
  - REG_W=5;
  - the NOP encoding 32'h00000013, used by the pipeline registers on bubble/flush.
- One natural sub-module: reg_scoreboard. It owns the pending vector with set/clear ports and returns eff_pend.

Test Plan:
1. lw x5 then add x6,x5,x1 (EX: ex_load_q=1, rd=5; ID: rs1=5): stall_pc=stall_ifid=bubble_idex=1 for exactly 1 cycle, then 0. hazard_state=1, then 0. stall_cycles=1.
2. div x7 issued; next instruction uses x7; long_done with long_rd=7 arrives 6 cycles later: stall held for 6 cycles and released in the long_done cycle. pending[7] goes 1 then 0.
3. branch_taken_ex=1 while ID holds a long_id op with rd=9 and a load-use match: flush_ifid=bubble_idex=1, stall=0, pending[9] stays 0, hazard_state=3.
4. long_done with long_rd=4, same cycle as an advancing long issue with rd_id=4: pending[4]=1 afterwards (set wins).
5. Sources and rd equal to x0, with load_id/long_id set: no stall ever, pending[0]=0.
6. stall_cycles preloaded near saturation (CNT_W forced to 4), 20 stall cycles: counter reads 15. Assert rst mid-LONG_STALL: next cycle pending=0, state=RUN, counter=0, outputs=0.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the ID-stage hazard scoreboard: state encodings,
// register-index width and the pipeline NOP encoding.
package hazard_scoreboard_pkg;

  localparam int REG_W = 5;
  localparam int NREG  = 32;

  // addi x0,x0,0 -- loaded by the pipeline registers on bubble/flush
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_LOAD  = 2'd1,
    HZ_LONG  = 2'd2,
    HZ_FLUSH = 2'd3
  } hz_state_e;

  // One-hot of a register index; x0 never produces a bit.
  function automatic logic [NREG-1:0] reg_onehot(input logic [REG_W-1:0] idx,
                                                 input logic             en);
    logic [NREG-1:0] m;
    m = '0;
    if (en && (idx != '0)) m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard interface. master = pipeline side (drives decode info,
// mul/div completion and EX redirect); slave = hazard scoreboard.
// Handshake: no valid/ready; every input is a level sampled each cycle,
// every control output is valid combinationally in the same cycle and the
// pipeline acts on it at the next rising edge.
interface hazard_scoreboard_if #(parameter int CNT_W = 16);
  logic [4:0]       rs1_id;
  logic [4:0]       rs2_id;
  logic             use_rs1_id;
  logic             use_rs2_id;
  logic [4:0]       rd_id;
  logic             RUWr_id;
  logic             load_id;
  logic             long_id;
  logic             long_done;
  logic [4:0]       long_rd;
  logic             branch_taken_ex;
  logic             stall_pc;
  logic             stall_ifid;
  logic             bubble_idex;
  logic             flush_ifid;
  logic [31:0]      pending;
  logic [1:0]       hazard_state;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_id, RUWr_id,
           load_id, long_id, long_done, long_rd, branch_taken_ex,
    input  stall_pc, stall_ifid, bubble_idex, flush_ifid, pending,
           hazard_state, stall_cycles
  );

  modport slave (
    input  rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_id, RUWr_id,
           load_id, long_id, long_done, long_rd, branch_taken_ex,
    output stall_pc, stall_ifid, bubble_idex, flush_ifid, pending,
           hazard_state, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard_reg_scoreboard.sv
// Pending-write vector for the mul/div unit. Set wins over clear on the
// same index; the clear is also applied combinationally (eff_pend_o)
// because the completing result is forwarded from WB that same cycle.
module reg_scoreboard
  import hazard_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en_i,
  input  logic [REG_W-1:0] set_idx_i,
  input  logic             clr_en_i,
  input  logic [REG_W-1:0] clr_idx_i,
  output logic [NREG-1:0]  pending_o,
  output logic [NREG-1:0]  eff_pend_o
);

  logic [NREG-1:0] pending_q, pending_d;
  logic [NREG-1:0] set_mask, clr_mask;

  // Next pending vector: clear completed writes, then set new issues.
  always_comb begin
    set_mask     = reg_onehot(set_idx_i, set_en_i);
    clr_mask     = reg_onehot(clr_idx_i, clr_en_i);
    pending_d    = (pending_q & ~clr_mask) | set_mask;
    pending_d[0] = 1'b0;
    eff_pend_o   = pending_q & ~clr_mask;
  end

  // Pending register; reset discards any in-flight mul/div results.
  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Detects hazards the EX bypass cannot cover (load-use, outstanding mul/div
// writes, taken-branch redirect) and drives PC / IF/ID / ID/EX controls.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_scoreboard_if.slave   hz
);

  hz_state_e        state_q, state_d;
  logic             ex_load_q, ex_load_d;
  logic [REG_W-1:0] ex_rd_q, ex_rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NREG-1:0]  pending, eff_pend;
  logic             load_haz, long_haz, advance, set_en;
  logic             stall_c, flush_c;

  reg_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (set_en),
    .set_idx_i  (hz.rd_id),
    .clr_en_i   (hz.long_done),
    .clr_idx_i  (hz.long_rd),
    .pending_o  (pending),
    .eff_pend_o (eff_pend)
  );

  // Hazard terms, priority resolution, control outputs and next state.
  always_comb begin
    load_haz = ex_load_q && (ex_rd_q != '0) &&
               ((hz.use_rs1_id && (hz.rs1_id == ex_rd_q)) ||
                (hz.use_rs2_id && (hz.rs2_id == ex_rd_q)));
    long_haz = (hz.use_rs1_id && (hz.rs1_id != '0) && eff_pend[hz.rs1_id]) ||
               (hz.use_rs2_id && (hz.rs2_id != '0) && eff_pend[hz.rs2_id]) ||
               (hz.RUWr_id    && (hz.rd_id  != '0) && eff_pend[hz.rd_id]);

    state_d   = HZ_RUN;
    stall_c   = 1'b0;
    flush_c   = 1'b0;
    advance   = 1'b0;
    if (hz.branch_taken_ex) begin
      flush_c = 1'b1;
      state_d = HZ_FLUSH;
    end else if (long_haz) begin
      stall_c = 1'b1;
      state_d = HZ_LONG;
    end else if (load_haz) begin
      stall_c = 1'b1;
      state_d = HZ_LOAD;
    end else begin
      advance = 1'b1;
    end

    set_en    = advance && hz.long_id && hz.RUWr_id && (hz.rd_id != '0);
    // A stall or flush places a bubble in EX, so nothing is tracked there.
    ex_load_d = advance && hz.load_id && hz.RUWr_id;
    ex_rd_d   = advance ? hz.rd_id : ex_rd_q;
    cnt_d     = (stall_c && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // State, EX tracker and saturating stall counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HZ_RUN;
      ex_load_q <= 1'b0;
      ex_rd_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ex_load_q <= ex_load_d;
      ex_rd_q   <= ex_rd_d;
      cnt_q     <= cnt_d;
    end
  end

  assign hz.stall_pc     = stall_c;
  assign hz.stall_ifid   = stall_c;
  assign hz.bubble_idex  = stall_c | flush_c;
  assign hz.flush_ifid   = flush_c;
  assign hz.pending      = pending;
  assign hz.hazard_state = state_q;
  assign hz.stall_cycles = cnt_q;

endmodule
